// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2
   } arb_state_t;

   // One 10-bit frame at 2605 clk per bit; the watchdog must outlast this.
   localparam int BAUD_FRAME_CLKS = 26050;

   // Index width for a requester count, never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request at or above ptr, wrapping.
// The request vector is doubled so that the wrap becomes a plain
// lowest-set-bit search over a masked vector.
module rr_pick
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int IDX_W   = idx_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] gnt_onehot,
   output logic [IDX_W-1:0]   gnt_idx,
   output logic               any
);

   logic [2*NUM_REQ-1:0] masked;

   // Upper copy is never masked, so a wrapped winner is always found there.
   assign masked = {req, req} & ({(2*NUM_REQ){1'b1}} << ptr);
   assign any    = |req;

   // Scan high to low so the lowest set bit is the last one written.
   always_comb begin
      gnt_idx = '0;
      for (int k = 2*NUM_REQ-1; k >= 0; k--) begin
         if (masked[k]) gnt_idx = IDX_W'(k % NUM_REQ);
      end
   end

   // One-hot form of the winner, empty when nobody is asking.
   always_comb begin
      gnt_onehot = '0;
      if (any) gnt_onehot = NUM_REQ'(1) << gnt_idx;
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte producers.
// IDLE grants round-robin and latches the byte, ISSUE strobes trmt,
// WAIT holds until tx_done or the watchdog expires.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ     = 3,
   parameter int TIMEOUT     = 32768,
   parameter int TO_W        = 16,
   // Set to 0 only for short-timeout test builds.
   parameter bit FRAME_CHECK = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [8*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]   ack,
   output logic [NUM_REQ-1:0]   sent,
   output logic                 trmt,
   output logic [7:0]           tx_data,
   input  logic                 tx_done,
   output logic                 busy,
   output logic                 timeout_err,
   input  logic                 clr_err
);

   localparam int IDX_W = idx_width(NUM_REQ);

   arb_state_t         state_reg, state_next;
   logic [IDX_W-1:0]   ptr_reg;
   logic [IDX_W-1:0]   gnt_idx_reg;
   logic [IDX_W-1:0]   ptr_next;
   logic [TO_W-1:0]    to_cnt_reg;
   logic [NUM_REQ-1:0] pick_onehot;
   logic [IDX_W-1:0]   pick_idx;
   logic               pick_any;
   logic               done_hit;
   logic               to_hit;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req        (req),
      .ptr        (ptr_reg),
      .gnt_onehot (pick_onehot),
      .gnt_idx    (pick_idx),
      .any        (pick_any)
   );

   // tx_done only counts in WAIT; a stale level in IDLE/ISSUE is ignored.
   assign done_hit = (state_reg == WAIT) && tx_done;
   assign to_hit   = (state_reg == WAIT) && !tx_done
                     && (to_cnt_reg == TO_W'(TIMEOUT-1));
   assign ptr_next = (gnt_idx_reg == IDX_W'(NUM_REQ-1)) ? '0
                                                         : gnt_idx_reg + 1'b1;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   // Next-state decode.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (pick_any) state_next = ISSUE;
         ISSUE:   state_next = WAIT;
         WAIT:    if (done_hit || to_hit) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Strobes decoded from state; ack is gated by rst_n so it drops at once.
   always_comb begin
      trmt = (state_reg == ISSUE);
      busy = (state_reg != IDLE);
      ack  = '0;
      if (rst_n && state_reg == IDLE) ack = pick_onehot;
   end

   // Grant latch, pointer, watchdog, completion pulse and sticky error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_reg     <= '0;
         gnt_idx_reg <= '0;
         tx_data     <= 8'h00;
         to_cnt_reg  <= '0;
         sent        <= '0;
         timeout_err <= 1'b0;
      end else begin
         sent <= '0;
         if (state_reg == IDLE && pick_any) begin
            gnt_idx_reg <= pick_idx;
            tx_data     <= req_data[{pick_idx, 3'b000} +: 8];
         end
         if (state_reg == ISSUE) begin
            to_cnt_reg <= '0;
         end else if (state_reg == WAIT && !tx_done) begin
            to_cnt_reg <= to_cnt_reg + 1'b1;
         end
         if (done_hit) sent <= NUM_REQ'(1) << gnt_idx_reg;
         if (done_hit || to_hit) ptr_reg <= ptr_next;
         // A new timeout outranks a clear in the same cycle.
         if (to_hit)       timeout_err <= 1'b1;
         else if (clr_err) timeout_err <= 1'b0;
      end
   end

   // Parameter sanity: legal requester count, counter width, frame length.
   a_num_req: assert property (@(posedge clk) (NUM_REQ >= 2) && (NUM_REQ <= 8));
   a_to_w:    assert property (@(posedge clk) TIMEOUT <= (1 << TO_W));
   a_frame:   assert property (@(posedge clk)
                 (FRAME_CHECK == 1'b0) || (TIMEOUT > BAUD_FRAME_CLKS));

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: behavioural transmitter, spec-level model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_uart_tx_arbiter;

   localparam int N          = 3;
   localparam int TIMEOUT    = 100;
   localparam int TO_W       = 8;
   localparam int FRAME_CLKS = 20;
   localparam int W_TRMT     = 0;
   localparam int W_SENT     = 1;
   localparam int W_ERR      = 2;
   localparam int W_ACK      = 3;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [N-1:0]   req = '0;
   logic [8*N-1:0] req_data = '0;
   logic [N-1:0]   ack;
   logic [N-1:0]   sent;
   logic           trmt;
   logic [7:0]     tx_data;
   logic           tx_done;
   logic           busy;
   logic           timeout_err;
   logic           clr_err = 1'b0;

   int checks = 0;
   int passed = 0;
   int ack_seen = 0;
   int sent_seen = 0;

   uart_tx_arbiter #(
      .NUM_REQ     (N),
      .TIMEOUT     (TIMEOUT),
      .TO_W        (TO_W),
      .FRAME_CHECK (1'b0)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .req_data    (req_data),
      .ack         (ack),
      .sent        (sent),
      .trmt        (trmt),
      .tx_data     (tx_data),
      .tx_done     (tx_done),
      .busy        (busy),
      .timeout_err (timeout_err),
      .clr_err     (clr_err)
   );

   always #5 clk = ~clk;

   // Transmitter stand-in: clears done on trmt, raises it FRAME_CLKS later.
   logic       tx_done_raw;
   int         frame_cnt;
   logic       tie_low = 1'b0;
   logic [7:0] frame_q[$];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_done_raw <= 1'b0;
         frame_cnt   <= 0;
      end else if (trmt) begin
         tx_done_raw <= 1'b0;
         frame_cnt   <= FRAME_CLKS;
         frame_q.push_back(tx_data);
         $display("frame start byte=%02h t=%0t", tx_data, $time);
      end else if (frame_cnt != 0) begin
         frame_cnt <= frame_cnt - 1;
         if (frame_cnt == 1) tx_done_raw <= 1'b1;
      end
   end
   assign tx_done = tx_done_raw & ~tie_low;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, exp, $time);
   endtask

   function automatic logic [N-1:0] onehot(input int i);
      logic [N-1:0] v;
      v = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   // Round-robin rule: first requester at or after p, wrapping.
   function automatic int rr_first(input logic [N-1:0] r, input int p);
      for (int i = 0; i < N; i++) if (r[(p + i) % N]) return (p + i) % N;
      return -1;
   endfunction

   // Spec-level model: phase 0 idle, 1 issue, 2 waiting for the frame.
   int         m_phase = 0;
   int         m_ptr = 0;
   int         m_gnt = 0;
   int         m_wait = 0;
   logic [7:0] m_byte = 8'h00;
   logic       m_err = 1'b0;
   logic [N-1:0] m_sent = '0;

   always @(negedge clk) begin : cmp
      int g;
      logic [N-1:0] e_ack;
      logic fired;
      if (!rst_n) begin
         m_phase = 0; m_ptr = 0; m_wait = 0;
         m_byte = 8'h00; m_err = 1'b0; m_sent = '0;
         check("rst_ack", ack, 0);
         check("rst_sent", sent, 0);
         check("rst_trmt", trmt, 0);
         check("rst_busy", busy, 0);
         check("rst_tx_data", tx_data, 0);
         check("rst_err", timeout_err, 0);
      end else begin
         g = rr_first(req, m_ptr);
         e_ack = (m_phase == 0 && g >= 0) ? onehot(g) : '0;
         check("ack", ack, e_ack);
         check("trmt", trmt, (m_phase == 1));
         check("busy", busy, (m_phase != 0));
         check("sent", sent, m_sent);
         check("tx_data", tx_data, m_byte);
         check("timeout_err", timeout_err, m_err);
         m_sent = '0;
         fired  = 1'b0;
         case (m_phase)
            0: if (g >= 0) begin
                  m_gnt = g;
                  m_byte = req_data[8*g +: 8];
                  m_phase = 1;
               end
            1: begin
                  m_phase = 2;
                  m_wait = 0;
               end
            default: begin
                  m_wait++;   // cycles spent waiting, this one included
                  if (tx_done) begin
                     m_sent = onehot(m_gnt);
                     m_ptr = (m_gnt + 1) % N;
                     m_phase = 0;
                  end else if (m_wait == TIMEOUT) begin
                     fired = 1'b1;
                     m_err = 1'b1;
                     m_ptr = (m_gnt + 1) % N;
                     m_phase = 0;
                  end
               end
         endcase
         if (!fired && clr_err) m_err = 1'b0;
      end
   end

   // Pulse counters for the one-ack/one-sent-per-frame checks.
   always @(negedge clk) begin
      if (rst_n) begin
         if (ack != '0) ack_seen++;
         if (sent != '0) sent_seen++;
      end
   end

   function automatic logic probe(input int which);
      case (which)
         W_TRMT:  return trmt;
         W_SENT:  return |sent;
         W_ERR:   return timeout_err;
         W_ACK:   return |ack;
         default: return 1'b0;
      endcase
   endfunction

   // Bounded wait; returns at the negedge where the signal is high.
   task automatic wait_for(input int which, input int budget, output int n);
      n = 0;
      @(negedge clk);
      while (!probe(which) && n < budget) begin
         n++;
         @(negedge clk);
      end
      if (!probe(which)) begin
         checks++;
         $display("FAIL wait_%0d: no event within %0d cycles", which, budget);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      int a0;
      int s0;
      logic [N-1:0] exp_ack5 [5];
      logic [7:0]   exp_byte5 [5];
      exp_ack5  = '{3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
      exp_byte5 = '{8'h33, 8'h11, 8'h22, 8'h33, 8'h11};

      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      // Single request from requester 1.
      req = 3'b010;
      req_data[15:8] = 8'hA5;
      wait_for(W_ACK, 10, n);
      check("single_ack", ack, 3'b010);
      tick();
      req = '0;
      wait_for(W_TRMT, 5, n);
      check("single_trmt_delay", n, 0);
      check("single_tx_data", tx_data, 8'hA5);
      wait_for(W_SENT, 100, n);
      check("single_sent_delay", n, FRAME_CLKS + 1);
      check("single_sent", sent, 3'b010);
      check("single_frames", frame_q.size(), 1);
      if (frame_q.size() > 0) check("single_byte", frame_q[0], 8'hA5);

      // All three held: ptr=2 first, then 0,1,2,0.
      tick();
      frame_q.delete();
      a0 = ack_seen;
      s0 = sent_seen;
      req = 3'b111;
      req_data = {8'h33, 8'h22, 8'h11};
      for (int k = 0; k < 5; k++) begin
         wait_for(W_ACK, 100, n);
         check("rr_ack", ack, exp_ack5[k]);
      end
      tick();
      req = '0;
      wait_for(W_SENT, 100, n);
      tick();
      check("rr_ack_pulses", ack_seen - a0, 5);
      check("rr_sent_pulses", sent_seen - s0, 5);
      check("rr_frames", frame_q.size(), 5);
      for (int k = 0; k < 5; k++)
         if (k < frame_q.size()) check("rr_byte", frame_q[k], exp_byte5[k]);

      // Data changed right after ack must not reach the frame.
      frame_q.delete();
      req = 3'b001;
      req_data[7:0] = 8'h3C;
      wait_for(W_ACK, 10, n);
      check("chg_ack", ack, 3'b001);
      tick();
      req_data[7:0] = 8'hFF;
      req = '0;
      wait_for(W_TRMT, 5, n);
      check("chg_tx_data", tx_data, 8'h3C);
      wait_for(W_SENT, 100, n);
      check("chg_frames", frame_q.size(), 1);
      if (frame_q.size() > 0) check("chg_byte", frame_q[0], 8'h3C);

      // Stale done: level left high from the last frame.
      tick();
      check("stale_premise", tx_done, 1'b1);
      req = 3'b010;
      req_data[15:8] = 8'h5A;
      wait_for(W_ACK, 10, n);
      check("stale_ack", ack, 3'b010);
      tick();
      req = '0;
      wait_for(W_TRMT, 5, n);
      wait_for(W_SENT, 100, n);
      check("stale_sent_delay", n, FRAME_CLKS + 1);
      check("stale_sent", sent, 3'b010);

      // Watchdog with tx_done held low.
      tick();
      tie_low = 1'b1;
      s0 = sent_seen;
      req = 3'b100;
      req_data[23:16] = 8'h77;
      wait_for(W_ACK, 10, n);
      check("wd_ack", ack, 3'b100);
      tick();
      req = '0;
      wait_for(W_TRMT, 5, n);
      wait_for(W_ERR, 300, n);
      check("wd_err_delay", n, TIMEOUT);
      tick();
      check("wd_no_sent", sent_seen - s0, 0);
      check("wd_idle", busy, 1'b0);
      tie_low = 1'b0;
      req = 3'b011;
      req_data[15:0] = {8'h55, 8'h44};
      wait_for(W_ACK, 10, n);
      check("wd_next_ack", ack, 3'b001);
      tick();
      req = '0;
      wait_for(W_TRMT, 5, n);
      check("wd_next_data", tx_data, 8'h44);
      wait_for(W_SENT, 100, n);
      check("wd_next_sent", sent, 3'b001);
      check("wd_err_sticky", timeout_err, 1'b1);
      tick();
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      @(negedge clk);
      check("wd_err_cleared", timeout_err, 1'b0);

      // Reset in the middle of WAIT.
      tick();
      req = 3'b010;
      req_data[15:8] = 8'h99;
      wait_for(W_ACK, 10, n);
      wait_for(W_TRMT, 5, n);
      repeat (10) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_trmt", trmt, 1'b0);
      check("mid_rst_ack", ack, 3'b000);
      check("mid_rst_sent", sent, 3'b000);
      check("mid_rst_tx_data", tx_data, 8'h00);
      tick();
      req = 3'b111;
      req_data = {8'hC3, 8'hB2, 8'hA1};
      rst_n = 1'b1;
      wait_for(W_ACK, 10, n);
      check("post_rst_ack", ack, 3'b001);
      tick();
      req = '0;
      wait_for(W_TRMT, 5, n);
      check("post_rst_data", tx_data, 8'hA1);
      wait_for(W_SENT, 100, n);
      check("post_rst_sent_delay", n, FRAME_CLKS + 1);
      check("post_rst_sent", sent, 3'b001);

      repeat (3) tick();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
